ram16x256_dp: RTL and testbench

- Simple dual-port synchronous RAM: 256 words x 16 bits, one write port and one read port, both on a single clock.
- Serves as the sample-history buffer of the decimating FIR filter in the FM receive chain.
- Samples are written at a circular write address; taps are read back at an independent read address.

---
 rtl/ram16x256_dp.sv | 41 ++++
 tb/tb_ram16x256_dp.sv | 111 +++++++++++
 2 files changed

// File: rtl/ram16x256_dp.sv
// ram16x256_dp: simple dual-port synchronous RAM, one write port and one
// registered read port on a single clock. Used as the sample-history buffer
// of the decimating FIR filter: samples go in at a circular write address,
// taps come out at an independent read address.
module ram16x256_dp #(
    parameter int DATA_WIDTH = 16,
    parameter int ADDR_WIDTH = 8,
    parameter int DEPTH      = 2 ** ADDR_WIDTH
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic [DATA_WIDTH-1:0] data,
    input  logic [ADDR_WIDTH-1:0] rdaddress,
    input  logic [ADDR_WIDTH-1:0] wraddress,
    input  logic                  wren,
    output logic [DATA_WIDTH-1:0] q
);

    // NOTE: the array is never touched by reset, so it maps onto block RAM;
    // its zero contents come from the configuration-time initial value.
    logic [DATA_WIDTH-1:0] mem [0:DEPTH-1] = '{default: '0};

    // Write port: store data when enabled and not held in reset.
    always_ff @(posedge clk) begin
        if (reset_n && wren) begin
            mem[wraddress] <= data;
        end
    end

    // Read port: one-cycle registered read, cleared by synchronous reset.
    // NOTE: non-blocking assignments make a same-address read on the write
    // edge return the old word; the new word shows up on the next read.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            q <= '0;
        end else begin
            q <= mem[rdaddress];
        end
    end

endmodule

// File: tb/tb_ram16x256_dp.sv
// tb_ram16x256_dp: directed, scoreboard-based bench for ram16x256_dp.
// Each step drives one clock's worth of inputs, pushes the q expected after
// that edge, then pops and checks it #1 after the edge.
module tb_ram16x256_dp;

    logic        clk = 1'b0;
    logic        reset_n;
    logic [15:0] data;
    logic [7:0]  rdaddress;
    logic [7:0]  wraddress;
    logic        wren;
    logic [15:0] q;

    typedef struct {
        logic [15:0] value;
        string       tag;
    } expect_t;

    expect_t     sb[$];
    logic [15:0] model [0:255];
    int          total = 0;
    int          bad   = 0;

    ram16x256_dp dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .data      (data),
        .rdaddress (rdaddress),
        .wraddress (wraddress),
        .wren      (wren),
        .q         (q)
    );

    always #5 clk = ~clk;

    // Drive one cycle, predict q from the reference model, then check it.
    task automatic step(input logic rst_n, input logic we, input logic [7:0] wa,
                        input logic [7:0] ra, input logic [15:0] d, input string tag);
        expect_t e;
        reset_n   = rst_n;
        wren      = we;
        wraddress = wa;
        rdaddress = ra;
        data      = d;
        e.tag     = tag;
        e.value   = rst_n ? model[ra] : 16'h0000;
        if (rst_n && we) model[wa] = d;
        sb.push_back(e);
        @(posedge clk);
        #1;
        total++;
        if (sb.size() == 0) begin
            bad++;
            $error("FAIL %s scoreboard empty", tag);
        end else begin
            e = sb.pop_front();
            assert (q === e.value)
            else begin
                bad++;
                $error("FAIL %s q=%h expected=%h", e.tag, q, e.value);
            end
        end
    endtask

    initial begin
        for (int i = 0; i < 256; i++) model[i] = 16'h0000;
        reset_n = 1'b0; wren = 1'b0; data = '0; rdaddress = '0; wraddress = '0;
        #2;

        // Reset held for two cycles with a write pending: q=0, write dropped.
        step(1'b0, 1'b1, 8'd5, 8'd5, 16'h1234, "reset_q0_a");
        step(1'b0, 1'b1, 8'd5, 8'd5, 16'h1234, "reset_q0_b");
        step(1'b1, 1'b0, 8'd0, 8'd5, 16'h0000, "reset_write_dropped");

        // Basic write at both address extremes, then read back.
        step(1'b1, 1'b1, 8'd0,   8'd1,   16'hBEEF, "basic_wr0");
        step(1'b1, 1'b1, 8'd255, 8'd2,   16'h8001, "basic_wr255");
        step(1'b1, 1'b0, 8'd0,   8'd0,   16'h0000, "basic_rd0");
        step(1'b1, 1'b0, 8'd0,   8'd255, 16'h0000, "basic_rd255");

        // Full sweep: mem[a] = a*257, then read all back-to-back.
        for (int a = 0; a < 256; a++)
            step(1'b1, 1'b1, 8'(a), 8'(255 - a), 16'(a * 257), "sweep_wr");
        for (int a = 0; a < 256; a++)
            step(1'b1, 1'b0, 8'd0, 8'(a), 16'h0000, "sweep_rd");

        // Same-address read during write returns the old word.
        step(1'b1, 1'b1, 8'd7, 8'd0, 16'h1111, "coll_setup");
        step(1'b1, 1'b1, 8'd7, 8'd7, 16'h2222, "coll_old");
        step(1'b1, 1'b0, 8'd0, 8'd7, 16'h0000, "coll_new");

        // Circular buffer: sample k at k mod 256, read (k+1) mod 256.
        for (int k = 1; k <= 300; k++)
            step(1'b1, 1'b1, 8'(k % 256), 8'((k + 1) % 256), 16'(k), "circ");
        // Idle cycles leave contents intact.
        step(1'b1, 1'b0, 8'd45, 8'd45,  16'hDEAD, "idle_rd45");
        step(1'b1, 1'b0, 8'd44, 8'd44,  16'hDEAD, "idle_rd44");
        step(1'b1, 1'b0, 8'd0,  8'd255, 16'hDEAD, "idle_rd255");

        // Mid-run reset pulse with a write pending: q=0, write dropped.
        step(1'b1, 1'b0, 8'd0,  8'd10, 16'h0000, "pre_reset_rd10");
        step(1'b0, 1'b1, 8'd10, 8'd10, 16'h0000, "midreset_q0");
        step(1'b1, 1'b0, 8'd0,  8'd10, 16'h0000, "post_reset_rd10");
        step(1'b1, 1'b0, 8'd0,  8'd44, 16'h0000, "post_reset_rd44");
        step(1'b1, 1'b0, 8'd0,  8'd7,  16'h0000, "post_reset_rd7");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
